// File: rtl/fpadd_share_ctrl_if.sv
// fpadd_share_ctrl_if: requester, shared-unit and result signals of the FP32 add share controller.
// The controller connects through the slave modport. The environment (requesters, the shared
// shift-add unit and the result consumer) connects through the master modport.
interface fpadd_share_ctrl_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
  // Requester side
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_op;

  // Shared shift-add unit controls and result
  logic        au_mode;
  logic        au_comp;
  logic        au_magcheck;
  logic        au_zero;
  logic        au_a_sign;
  logic        au_b_sign;
  logic [7:0]  au_big_exp;
  logic [7:0]  au_small_exp;
  logic [23:0] au_big_man;
  logic [23:0] au_small_man;
  logic [31:0] au_result;

  // Result side
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_data;
  logic [ID_W-1:0] res_id;

  modport slave (
    input  req_valid, req_a, req_b, req_op, au_result, res_ready,
    output req_ready, au_mode, au_comp, au_magcheck, au_zero, au_a_sign, au_b_sign,
           au_big_exp, au_small_exp, au_big_man, au_small_man,
           res_valid, res_data, res_id
  );

  modport master (
    output req_valid, req_a, req_b, req_op, au_result, res_ready,
    input  req_ready, au_mode, au_comp, au_magcheck, au_zero, au_a_sign, au_b_sign,
           au_big_exp, au_small_exp, au_big_man, au_small_man,
           res_valid, res_data, res_id
  );
endinterface

// File: rtl/fpadd_share_ctrl.sv
// fpadd_share_ctrl: round-robin arbiter and two-stage sequencer sharing one combinational FP32
// shift-add unit among NUM_REQ requesters.
//   S0: round-robin grant over req_valid starting at rr_ptr.
//   S1: operand register; pre-orders big/small fields and drives the au_* controls.
//   S2: result register; resolves zero-operand cases around the shared unit.
// Build macro FPADD_SHARE_CTRL_STATS_EN adds a 16-bit op_count port counting S0 handshakes.
module fpadd_share_ctrl #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  fpadd_share_ctrl_if.slave  bus
`ifdef FPADD_SHARE_CTRL_STATS_EN
  ,
  output logic [15:0]        op_count
`endif
);

  // One extra bit so rr_ptr + offset can be wrapped for non-power-of-two NUM_REQ.
  localparam int unsigned    PW        = ID_W + 1;
  localparam logic [PW-1:0]  NUM_REQ_P = PW'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ - 1);

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  logic [ID_W-1:0] rr_ptr_q;

  logic            s1_valid_q;
  logic [31:0]     s1_a_q;
  logic [31:0]     s1_b_q;
  logic            s1_op_q;
  logic [ID_W-1:0] s1_id_q;

  logic            s2_valid_q;
  logic [31:0]     s2_data_q;
  logic [ID_W-1:0] s2_id_q;

  // ---------------------------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------------------------
  logic            s1_load;
  logic            s2_load;
  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic [PW-1:0]   grant_sum;
  logic            handshake;

  // Stage enables: a full S2 stalls everything behind it while res_ready is low.
  always_comb begin
    s2_load   = ~s2_valid_q | bus.res_ready;
    s1_load   = ~s1_valid_q | s2_load;
    handshake = grant_found & s1_load;
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    grant_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_sum = {1'b0, rr_ptr_q} + PW'(k);
      if (grant_sum >= NUM_REQ_P) begin
        grant_sum = grant_sum - NUM_REQ_P;
      end
      if (!grant_found && bus.req_valid[grant_sum[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = grant_sum[ID_W-1:0];
      end
    end
  end

  // One-hot accept to the winner; held low during reset so no requester sees a false accept.
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && handshake) begin
      bus.req_ready[grant_id] = 1'b1;
    end
  end

  // Pointer moves past the winner on every handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (handshake) begin
      rr_ptr_q <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // S1: operand register
  // ---------------------------------------------------------------------------------------------
  // Capture the winner's operands; S1 empties when it hands off without a new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= 1'b0;
      s1_id_q    <= '0;
    end else if (s1_load) begin
      s1_valid_q <= handshake;
      if (handshake) begin
        s1_a_q  <= bus.req_a[32*grant_id +: 32];
        s1_b_q  <= bus.req_b[32*grant_id +: 32];
        s1_op_q <= bus.req_op[grant_id];
        s1_id_q <= grant_id;
      end
    end
  end

  logic [30:0] a_mag;
  logic [30:0] b_mag;
  logic        esub;
  logic        a_gt;
  logic        mag_eq;
  logic        a_exp_zero;
  logic        b_exp_zero;
  logic [30:0] big_op;
  logic [30:0] small_op;

  // Magnitude ordering of the S1 operands; equal magnitudes pick B, which is equivalent.
  always_comb begin
    a_mag      = s1_a_q[30:0];
    b_mag      = s1_b_q[30:0];
    esub       = s1_a_q[31] ^ s1_b_q[31] ^ s1_op_q;
    a_gt       = a_mag > b_mag;
    mag_eq     = a_mag == b_mag;
    a_exp_zero = s1_a_q[30:23] == 8'd0;
    b_exp_zero = s1_b_q[30:23] == 8'd0;
    big_op     = a_gt ? a_mag : b_mag;
    small_op   = a_gt ? b_mag : a_mag;
  end

  // Shared-unit controls, forced to zero whenever S1 holds nothing.
  always_comb begin
    bus.au_mode      = s1_valid_q & s1_op_q;
    bus.au_comp      = s1_valid_q & a_gt;
    bus.au_magcheck  = s1_valid_q & mag_eq & ~esub;
    bus.au_zero      = s1_valid_q & mag_eq & esub;
    bus.au_a_sign    = s1_valid_q & s1_a_q[31];
    bus.au_b_sign    = s1_valid_q & s1_b_q[31];
    bus.au_big_exp   = '0;
    bus.au_small_exp = '0;
    bus.au_big_man   = '0;
    bus.au_small_man = '0;
    if (s1_valid_q) begin
      bus.au_big_exp   = big_op[30:23];
      bus.au_small_exp = small_op[30:23];
      bus.au_big_man   = {big_op[30:23] != 8'd0, big_op[22:0]};
      bus.au_small_man = {small_op[30:23] != 8'd0, small_op[22:0]};
    end
  end

  // ---------------------------------------------------------------------------------------------
  // S2: result register
  // ---------------------------------------------------------------------------------------------
  logic [31:0] s1_result;

  // Exact cancellation and zero/subnormal operands bypass the shared unit.
  always_comb begin
    if (mag_eq && esub) begin
      s1_result = 32'h0000_0000;
    end else if (a_exp_zero && !b_exp_zero) begin
      s1_result = {s1_b_q[31] ^ s1_op_q, s1_b_q[30:0]};
    end else if (b_exp_zero && !a_exp_zero) begin
      s1_result = s1_a_q;
    end else if (a_exp_zero && b_exp_zero) begin
      s1_result = 32'h0000_0000;
    end else begin
      s1_result = bus.au_result;
    end
  end

  // Result register; a pop and a fresh S1 transfer in the same cycle leave no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_id_q    <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= s1_result;
        s2_id_q   <= s1_id_q;
      end
    end
  end

  // Result outputs come straight from S2, so they hold while stalled.
  always_comb begin
    bus.res_valid = s2_valid_q;
    bus.res_data  = s2_data_q;
    bus.res_id    = s2_id_q;
  end

`ifdef FPADD_SHARE_CTRL_STATS_EN
  // Handshake counter; wraps from 0xFFFF to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (handshake) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpadd_share_ctrl.sv
// tb_fpadd_share_ctrl: scoreboard bench for fpadd_share_ctrl. A behavioural shift-add unit closes
// the au_* loop; expected results come from a real-number reference on the raw operands.
module tb_fpadd_share_ctrl;
  localparam int unsigned NUM_REQ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
`ifdef FPADD_SHARE_CTRL_STATS_EN
  logic [15:0] op_count;
`endif

  fpadd_share_ctrl_if #(.NUM_REQ(NUM_REQ)) bus ();

  fpadd_share_ctrl #(.NUM_REQ(NUM_REQ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef FPADD_SHARE_CTRL_STATS_EN
    ,
    .op_count (op_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural shared unit: align, add/sub, normalise, truncate.
  logic [24:0] u_big, u_small, u_sum;
  logic [7:0]  u_exp, u_d;
  logic        u_sign, u_esub;
  logic [31:0] u_res;
  always_comb begin
    u_esub  = bus.au_a_sign ^ bus.au_b_sign ^ bus.au_mode;
    u_sign  = (bus.au_comp || bus.au_magcheck) ? bus.au_a_sign : (bus.au_b_sign ^ bus.au_mode);
    u_d     = bus.au_big_exp - bus.au_small_exp;
    u_big   = {1'b0, bus.au_big_man};
    u_small = (u_d > 8'd24) ? 25'd0 : ({1'b0, bus.au_small_man} >> u_d);
    u_sum   = u_esub ? (u_big - u_small) : (u_big + u_small);
    u_exp   = bus.au_big_exp;
    u_res   = 32'd0;
    if (u_sum[24]) begin
      u_res = {u_sign, u_exp + 8'd1, u_sum[23:1]};
    end else if (u_sum != 25'd0) begin
      for (int k = 0; k < 24; k++) begin
        if (!u_sum[23]) begin
          u_sum = {u_sum[23:0], 1'b0};
          u_exp = u_exp - 8'd1;
        end
      end
      u_res = {u_sign, u_exp, u_sum[22:0]};
    end
    bus.au_result = u_res;
  end

  // Reference model on raw operands (subnormals as zero, zero results as +0).
  function automatic real fp_to_real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_fp(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic op);
    real ra, rb;
    ra = fp_to_real(a);
    rb = fp_to_real(b);
    return real_to_fp(op ? (ra - rb) : (ra + rb));
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [1:0]  id;
  } sb_t;

  sb_t sb_q[$];
  int  grant_q[$];
  int  hs_count = 0;

  // Monitor: pops/compares on result handshakes, pushes expectations on request handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.res_valid && bus.res_ready) begin
        if (sb_q.size() == 0) begin
          check("spurious_res", 32'(bus.res_valid), 32'd0);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("res_data", bus.res_data, e.data);
          check("res_id", 32'(bus.res_id), 32'(e.id));
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          sb_t n;
          n.data = ref_add(bus.req_a[32*i +: 32], bus.req_b[32*i +: 32], bus.req_op[i]);
          n.id   = 2'(i);
          sb_q.push_back(n);
          grant_q.push_back(i);
          hs_count++;
        end
      end
    end
  end

  // Drive one request and wait (bounded) for its accept; returns 1 ns after the accepting edge.
  task automatic send(input int id, input logic [31:0] a, input logic [31:0] b, input logic op);
    logic ok;
    int   n;
    bus.req_a[32*id +: 32] = a;
    bus.req_b[32*id +: 32] = b;
    bus.req_op[id]         = op;
    bus.req_valid[id]      = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = bus.req_ready[id];
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 20);
    bus.req_valid[id] = 1'b0;
    check("send_hs", 32'(ok), 32'd1);
  endtask

  // Wait (bounded) for a result and compare it against a directed constant.
  task automatic wait_res(input string tag, input logic [31:0] exp_data, input int exp_id);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.res_valid && n < 10);
    check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    check({tag, "_data"}, bus.res_data, exp_data);
    check({tag, "_id"}, 32'(bus.res_id), 32'(exp_id));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.res_ready = 1'b1;

    // Reset values, with all requesters asking
    #1 rst_n = 1'b0;
    bus.req_valid = '1;
    #2;
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", bus.res_data, 32'd0);
    check("rst_res_id", 32'(bus.res_id), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_au_ctl", 32'({bus.au_mode, bus.au_comp, bus.au_magcheck, bus.au_zero,
                             bus.au_a_sign, bus.au_b_sign}), 32'd0);
    check("rst_au_fields", 32'({bus.au_big_exp, bus.au_small_exp} | bus.au_big_man[15:0]
                               | bus.au_small_man[15:0]), 32'd0);
`ifdef FPADD_SHARE_CTRL_STATS_EN
    check("rst_op_count", 32'(op_count), 32'd0);
`endif
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single add with latency check
    send(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    @(negedge clk);
    check("lat_t1_valid", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    check("lat_t2_valid", 32'(bus.res_valid), 32'd1);
    check("add_data", bus.res_data, 32'h4000_0000);
    check("add_id", 32'(bus.res_id), 32'd0);
    @(posedge clk);
    #1;

    // Subtract, then exact cancellation
    send(2, 32'h4040_0000, 32'h3F80_0000, 1'b1);
    @(negedge clk);
    check("sub_au_zero", 32'(bus.au_zero), 32'd0);
    check("sub_au_comp", 32'(bus.au_comp), 32'd1);
    check("sub_au_mode", 32'(bus.au_mode), 32'd1);
    check("sub_au_big_exp", 32'(bus.au_big_exp), 32'd128);
    check("sub_au_small_man", 32'(bus.au_small_man), 32'h80_0000);
    wait_res("sub", 32'h4000_0000, 2);
    send(2, 32'h4000_0000, 32'h4000_0000, 1'b1);
    @(negedge clk);
    check("cancel_au_zero", 32'(bus.au_zero), 32'd1);
    wait_res("cancel", 32'h0000_0000, 2);

    // Zero operands
    send(3, 32'h0000_0000, 32'h3FC0_0000, 1'b1);
    wait_res("zero_a", 32'hBFC0_0000, 3);
    send(3, 32'h0000_0000, 32'h0000_0000, 1'b0);
    wait_res("zero_both", 32'h0000_0000, 3);

    // Fairness: all requesters continuously valid, pointer starts at 0
    grant_q.delete();
    bus.req_a   = {32'h3F40_0000, 32'hBF80_0000, 32'h40C0_0000, 32'h3F80_0000};
    bus.req_b   = {32'h4040_0000, 32'h3E80_0000, 32'h4000_0000, 32'h3F00_0000};
    bus.req_op  = 4'b1010;
    bus.req_valid = '1;
    repeat (12) @(posedge clk);
    #1 bus.req_valid = '0;
    check("fair_count", 32'(grant_q.size()), 32'd12);
    for (int k = 0; k < grant_q.size(); k++) begin
      check("fair_order", 32'(grant_q[k]), 32'(k % NUM_REQ));
    end
    repeat (3) @(posedge clk);
    #1;
    check("fair_drained", 32'(sb_q.size()), 32'd0);

    // Backpressure with two operations in flight
    send(1, 32'h3FC0_0000, 32'h3E80_0000, 1'b0);
    send(2, 32'h4040_0000, 32'h3F00_0000, 1'b1);
    bus.res_ready = 1'b0;
    bus.req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.res_valid), 32'd1);
      check("bp_data", bus.res_data, 32'h3FE0_0000);
      check("bp_id", 32'(bus.res_id), 32'd1);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("bp_rel1_data", bus.res_data, 32'h3FE0_0000);
    @(negedge clk);
    check("bp_rel2_valid", 32'(bus.res_valid), 32'd1);
    check("bp_rel2_data", bus.res_data, 32'h4020_0000);
    check("bp_rel2_id", 32'(bus.res_id), 32'd2);
    @(posedge clk);
    #1;
`ifdef FPADD_SHARE_CTRL_STATS_EN
    check("op_count_run", 32'(op_count), 32'(16'(hs_count)));
`endif

    // Reset with both stages full
    send(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    send(1, 32'h4000_0000, 32'h3F80_0000, 1'b0);
    bus.req_valid = '1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("mid_rst_au_exp", 32'(bus.au_big_exp), 32'd0);
`ifdef FPADD_SHARE_CTRL_STATS_EN
    check("mid_rst_op_count", 32'(op_count), 32'd0);
`endif
    sb_q.delete();
    hs_count = 0;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(bus.res_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(3, 32'h3F80_0000, 32'h3F00_0000, 1'b1);
    wait_res("post_rst", 32'h3F00_0000, 3);
`ifdef FPADD_SHARE_CTRL_STATS_EN
    check("op_count_post_rst", 32'(op_count), 32'(16'(hs_count)));
`endif
    repeat (2) @(posedge clk);
    #1;
    check("final_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
